ritc_vcdl_scan_ctrl: RTL and testbench

//  Sequences a phase scan of the RITC VCDL feedback. Enables the VCDL, steps the MMCM fine phase shift
//  of the feedback sample clock, counts vcdl_ps_q highs per step and locates the first low->high edge.

---
 rtl/ritc_vcdl_scan_pkg.sv | 16 +
 rtl/ritc_vcdl_scan_hist.sv | 32 +++
 rtl/ritc_vcdl_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_ritc_vcdl_scan_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ritc_vcdl_scan_pkg.sv
// Shared constants for the RITC VCDL phase-scan controller: state codes and default widths.
package ritc_vcdl_scan_pkg;

  localparam int unsigned DefSampleLog2   = 8;
  localparam int unsigned DefSettleCycles = 64;
  localparam int unsigned DefStepW        = 10;
  localparam int unsigned DefPsTimeout    = 1023;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSettle = 3'd1;
  localparam logic [2:0] StSample = 3'd2;
  localparam logic [2:0] StRecord = 3'd3;
  localparam logic [2:0] StStep   = 3'd4;
  localparam logic [2:0] StReturn = 3'd5;

endpackage

// File: rtl/ritc_vcdl_scan_hist.sv
// Per-step high-count histogram: simple dual-port RAM, write port from RECORD, registered read.
module ritc_vcdl_scan_hist
  import ritc_vcdl_scan_pkg::*;
#(
  parameter int unsigned AddrW = DefStepW,
  parameter int unsigned DataW = DefSampleLog2 + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [2**AddrW];
  logic [DataW-1:0] rdata_q;

  // RAM contents are deliberately not reset so stale entries survive between scans.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ritc_vcdl_scan_ctrl.sv
// RITC VCDL feedback phase scan: step MMCM fine phase, count feedback highs, find first rising edge.
// Optional histogram RAM enabled by defining RITC_VCDL_SCAN_HIST_EN.
module ritc_vcdl_scan_ctrl
  import ritc_vcdl_scan_pkg::*;
#(
  parameter int unsigned SAMPLE_LOG2   = DefSampleLog2,
  parameter int unsigned SETTLE_CYCLES = DefSettleCycles,
  parameter int unsigned STEP_W        = DefStepW,
  parameter int unsigned PS_TIMEOUT    = DefPsTimeout
) (
  input  logic                 user_clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [STEP_W-1:0]    num_steps_i,
  input  logic                 vcdl_ps_q_i,
  input  logic                 ps_done_i,
  output logic                 ps_en_o,
  output logic                 ps_incdec_o,
  output logic                 vcdl_enable_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 edge_found_o,
  output logic [STEP_W-1:0]    edge_step_o,
  output logic [SAMPLE_LOG2:0] last_count_o,
  input  logic [STEP_W-1:0]    hist_addr_i,
  output logic [SAMPLE_LOG2:0] hist_data_o
);

  localparam int unsigned CntW    = SAMPLE_LOG2 + 1;
  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned ToW     = $clog2(PS_TIMEOUT + 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [ToW-1:0]     ToLast     = ToW'(PS_TIMEOUT - 1);
  localparam logic [CntW-1:0]    HiThresh   = CntW'(2 ** (SAMPLE_LOG2 - 1));

  logic [2:0]             state_q, state_d;
  logic [STEP_W-1:0]      num_steps_q, num_steps_d;
  logic [STEP_W-1:0]      step_q, step_d;
  logic [SettleW-1:0]     settle_cnt_q, settle_cnt_d;
  logic [SAMPLE_LOG2-1:0] samp_cnt_q, samp_cnt_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [CntW-1:0]        last_count_q, last_count_d;
  logic [STEP_W-1:0]      edge_step_q, edge_step_d;
  logic [ToW-1:0]         to_cnt_q, to_cnt_d;
  logic                   prev_hi_q, prev_hi_d;
  logic                   edge_found_q, edge_found_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;
  logic                   vcdl_en_q, vcdl_en_d;
  logic                   ps_en_q, ps_en_d;
  logic                   ps_incdec_q, ps_incdec_d;
  logic                   ps_wait_q, ps_wait_d;
  logic                   abort_pend_q, abort_pend_d;
  logic [1:0]             sync_q;
  logic                   hist_we, hi, ps_ack, ps_timeout;

  assign hi         = (count_q >= HiThresh);
  // PSDONE coincident with our own PSEN pulse is never taken as the acknowledge.
  assign ps_ack     = ps_wait_q && !ps_en_q && ps_done_i;
  assign ps_timeout = ps_wait_q && !ps_ack && (to_cnt_q == ToLast);

  always_comb begin
    state_d      = state_q;
    num_steps_d  = num_steps_q;
    step_d       = step_q;
    settle_cnt_d = settle_cnt_q;
    samp_cnt_d   = samp_cnt_q;
    count_d      = count_q;
    last_count_d = last_count_q;
    edge_step_d  = edge_step_q;
    to_cnt_d     = to_cnt_q;
    prev_hi_d    = prev_hi_q;
    edge_found_d = edge_found_q;
    err_d        = err_q;
    vcdl_en_d    = vcdl_en_q;
    ps_incdec_d  = ps_incdec_q;
    ps_wait_d    = ps_wait_q;
    abort_pend_d = abort_pend_q;
    ps_en_d      = 1'b0;
    done_d       = 1'b0;
    hist_we      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          num_steps_d  = num_steps_i;
          err_d        = 1'b0;
          edge_found_d = 1'b0;
          edge_step_d  = '0;
          vcdl_en_d    = 1'b1;
          step_d       = '0;
          prev_hi_d    = 1'b0;
          settle_cnt_d = '0;
          ps_incdec_d  = 1'b1;
          abort_pend_d = 1'b0;
          state_d      = StSettle;
        end
      end
      StSettle: begin
        settle_cnt_d = settle_cnt_q + SettleW'(1);
        if (abort_i) begin
          state_d = StReturn;
        end else if (settle_cnt_q == SettleLast) begin
          samp_cnt_d = '0;
          count_d    = '0;
          state_d    = StSample;
        end
      end
      StSample: begin
        count_d    = count_q + CntW'(sync_q[1]);
        samp_cnt_d = samp_cnt_q + SAMPLE_LOG2'(1);
        if (abort_i)                state_d = StReturn;
        else if (samp_cnt_q == '1)  state_d = StRecord;
      end
      StRecord: begin
        last_count_d = count_q;
        hist_we      = 1'b1;
        prev_hi_d    = hi;
        if (!edge_found_q && !prev_hi_q && hi && (step_q != '0)) begin
          edge_found_d = 1'b1;
          edge_step_d  = step_q;
        end
        if (abort_i || (step_q == num_steps_q)) state_d = StReturn;
        else                                    state_d = StStep;
      end
      StStep: begin
        if (!ps_wait_q) begin
          if (abort_i) begin
            state_d = StReturn;
          end else begin
            ps_en_d     = 1'b1;
            ps_incdec_d = 1'b1;
            ps_wait_d   = 1'b1;
            to_cnt_d    = '0;
          end
        end else if (ps_ack) begin
          // The completed increment is counted here exactly once, even when aborting.
          ps_wait_d    = 1'b0;
          step_d       = step_q + STEP_W'(1);
          settle_cnt_d = '0;
          abort_pend_d = 1'b0;
          state_d      = (abort_pend_q || abort_i) ? StReturn : StSettle;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
          if (abort_i) abort_pend_d = 1'b1;
        end
      end
      StReturn: begin
        if (!ps_wait_q) begin
          if (step_q == '0) begin
            vcdl_en_d   = 1'b0;
            done_d      = 1'b1;
            ps_incdec_d = 1'b1;
            state_d     = StIdle;
          end else begin
            ps_en_d     = 1'b1;
            ps_incdec_d = 1'b0;
            ps_wait_d   = 1'b1;
            to_cnt_d    = '0;
          end
        end else if (ps_ack) begin
          ps_wait_d = 1'b0;
          step_d    = step_q - STEP_W'(1);
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    // Phase position is unknown after a lost PSDONE, so give up without returning.
    if (ps_timeout) begin
      err_d        = 1'b1;
      vcdl_en_d    = 1'b0;
      done_d       = 1'b1;
      ps_wait_d    = 1'b0;
      abort_pend_d = 1'b0;
      ps_incdec_d  = 1'b1;
      step_d       = '0;
      state_d      = StIdle;
    end
  end

  always_ff @(posedge user_clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      num_steps_q  <= '0;
      step_q       <= '0;
      settle_cnt_q <= '0;
      samp_cnt_q   <= '0;
      count_q      <= '0;
      last_count_q <= '0;
      edge_step_q  <= '0;
      to_cnt_q     <= '0;
      prev_hi_q    <= 1'b0;
      edge_found_q <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      vcdl_en_q    <= 1'b0;
      ps_en_q      <= 1'b0;
      ps_incdec_q  <= 1'b1;
      ps_wait_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      sync_q       <= '0;
    end else begin
      state_q      <= state_d;
      num_steps_q  <= num_steps_d;
      step_q       <= step_d;
      settle_cnt_q <= settle_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      count_q      <= count_d;
      last_count_q <= last_count_d;
      edge_step_q  <= edge_step_d;
      to_cnt_q     <= to_cnt_d;
      prev_hi_q    <= prev_hi_d;
      edge_found_q <= edge_found_d;
      err_q        <= err_d;
      done_q       <= done_d;
      vcdl_en_q    <= vcdl_en_d;
      ps_en_q      <= ps_en_d;
      ps_incdec_q  <= ps_incdec_d;
      ps_wait_q    <= ps_wait_d;
      abort_pend_q <= abort_pend_d;
      sync_q       <= {sync_q[0], vcdl_ps_q_i};
    end
  end

  assign ps_en_o       = ps_en_q;
  assign ps_incdec_o   = ps_incdec_q;
  assign vcdl_enable_o = vcdl_en_q;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign edge_found_o  = edge_found_q;
  assign edge_step_o   = edge_step_q;
  assign last_count_o  = last_count_q;

`ifdef RITC_VCDL_SCAN_HIST_EN
  ritc_vcdl_scan_hist #(
    .AddrW(STEP_W),
    .DataW(CntW)
  ) u_hist (
    .clk_i   (user_clk_i),
    .rst_i   (rst_i),
    .we_i    (hist_we),
    .waddr_i (step_q),
    .wdata_i (count_q),
    .raddr_i (hist_addr_i),
    .rdata_o (hist_data_o)
  );
`else
  logic unused_hist;
  assign unused_hist = ^{hist_we, hist_addr_i};
  assign hist_data_o = '0;
`endif

endmodule

// File: tb/tb_ritc_vcdl_scan_ctrl.sv
// Scoreboard bench for ritc_vcdl_scan_ctrl with an MMCM phase-shift model and a feedback model.
module tb_ritc_vcdl_scan_ctrl;

  localparam int Settle  = 64;
  localparam int Samples = 256;
  localparam int Tmo     = 1023;

  logic       clk = 1'b0;
  logic       rst, start, abort, vcdl_ps, ps_done;
  logic [9:0] num_steps, hist_addr;
  logic       ps_en, ps_incdec, vcdl_en, busy, done, err, edge_found;
  logic [9:0] edge_step;
  logic [8:0] last_count, hist_data;

  ritc_vcdl_scan_ctrl u_dut (
    .user_clk_i    (clk),
    .rst_i         (rst),
    .start_i       (start),
    .abort_i       (abort),
    .num_steps_i   (num_steps),
    .vcdl_ps_q_i   (vcdl_ps),
    .ps_done_i     (ps_done),
    .ps_en_o       (ps_en),
    .ps_incdec_o   (ps_incdec),
    .vcdl_enable_o (vcdl_en),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .edge_found_o  (edge_found),
    .edge_step_o   (edge_step),
    .last_count_o  (last_count),
    .hist_addr_i   (hist_addr),
    .hist_data_o   (hist_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ef;
    int es;
    int er;
    int inc;
    int dec;
    int lc;
  } exp_t;

  exp_t sb_q[$];
  int   hist_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   inc_cnt = 0, dec_cnt = 0, done_cnt = 0, done_base = 0;
  int   psen_cyc = 0, done_cyc = 0, start_cyc = 0;
  int   phase = 0, ps_cnt = 0, mode = 0;
  bit   ps_hang = 1'b0, hist_req = 1'b0, tgl = 1'b0;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // MMCM model: PSDONE five cycles after PSEN; feedback level depends on phase position.
  always @(negedge clk) begin
    if (rst) begin
      phase   = 0;
      ps_cnt  = 0;
      ps_done = 1'b0;
    end else begin
      ps_done = 1'b0;
      if (ps_cnt > 0) begin
        ps_cnt--;
        if (ps_cnt == 0) ps_done = 1'b1;
      end
      if (ps_en && !ps_hang) begin
        ps_cnt = 5;
        phase  = phase + (ps_incdec ? 1 : -1);
      end
    end
    tgl = ~tgl;
    case (mode)
      0:       vcdl_ps = (phase >= 7);
      1:       vcdl_ps = (phase == 2) ? tgl : (phase >= 4);
      default: vcdl_ps = 1'b1;
    endcase
  end

  // Monitor: count PSENs, compare histogram reads and finished scans against the queues.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (ps_en) begin
        if (ps_incdec) inc_cnt++;
        else           dec_cnt++;
        psen_cyc = cyc;
      end
      if (hist_req) begin
        if (hist_q.size() == 0) check("hist_queue", hist_q.size(), 1);
        else                    check("hist_data", hist_data, hist_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (sb_q.size() == 0) begin
          check("unexpected_done", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          check("edge_found", edge_found, e.ef);
          check("edge_step", edge_step, e.es);
          check("err", err, e.er);
          check("inc_psen", inc_cnt, e.inc);
          check("dec_psen", dec_cnt, e.dec);
          check("last_count", last_count, e.lc);
          check("busy_at_done", busy, 0);
          check("vcdl_en_at_done", vcdl_en, 0);
        end
      end
    end
  end

  task automatic start_scan(input int n, input exp_t e, input bit push);
    @(negedge clk);
    inc_cnt   = 0;
    dec_cnt   = 0;
    done_base = done_cnt;
    if (push) sb_q.push_back(e);
    num_steps = 10'(n);
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20000 && done_cnt == done_base; i++) @(negedge clk);
    check("scan_done", done_cnt, done_base + 1);
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_inc(input int k);
    for (int i = 0; i < 8000 && inc_cnt < k; i++) @(negedge clk);
    check("psen_reached", int'(inc_cnt >= k), 1);
  endtask

  task automatic pulse_abort();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ps_en"}, ps_en, 0);
    check({tag, "_incdec"}, ps_incdec, 1);
    check({tag, "_vcdl_en"}, vcdl_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_edge_found"}, edge_found, 0);
    check({tag, "_edge_step"}, edge_step, 0);
    check({tag, "_last_count"}, last_count, 0);
    check({tag, "_hist_data"}, hist_data, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; num_steps = '0; hist_addr = '0;
    vcdl_ps = 1'b0; ps_done = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;

    // Rising edge at step 7; a start while busy must be ignored.
    mode = 0;
    start_scan(16, '{ef: 1, es: 7, er: 0, inc: 16, dec: 16, lc: 256}, 1'b1);
    wait_inc(2);
    check("vcdl_en_busy", vcdl_en, 1);
    check("busy_mid_scan", busy, 1);
    @(negedge clk);
    num_steps = 10'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Histogram readback of the scan above.
    for (int a = 0; a <= 16; a++) begin
      @(negedge clk);
      hist_addr = 10'(a);
      hist_req  = 1'b1;
`ifdef RITC_VCDL_SCAN_HIST_EN
      hist_q.push_back((a >= 7) ? 256 : 0);
`else
      hist_q.push_back(0);
`endif
    end
    @(negedge clk);
    hist_req = 1'b0;

    // Exactly half high at step 2 counts as high; later low->high does not re-trigger.
    mode = 1;
    start_scan(6, '{ef: 1, es: 2, er: 0, inc: 6, dec: 6, lc: 256}, 1'b1);
    wait_done();

    // High from step 0: step 0 never qualifies as an edge.
    mode = 2;
    start_scan(2, '{ef: 0, es: 0, er: 0, inc: 2, dec: 2, lc: 256}, 1'b1);
    wait_done();

    // PSDONE never arrives: timeout after Tmo cycles of waiting.
    mode = 0;
    ps_hang = 1'b1;
    start_scan(3, '{ef: 0, es: 0, er: 1, inc: 1, dec: 0, lc: 0}, 1'b1);
    wait_done();
    check("timeout_cycles", done_cyc - psen_cyc, Tmo);
    check("err_sticky", err, 1);
    ps_hang = 1'b0;

    // Abort in SAMPLE of step 5: edge at 2 already found, five decrements.
    mode = 1;
    start_scan(16, '{ef: 1, es: 2, er: 0, inc: 5, dec: 5, lc: 256}, 1'b1);
    wait_inc(5);
    repeat (150) @(negedge clk);
    pulse_abort();
    wait_done();

    // Abort while the third increment is outstanding: that step counts once.
    mode = 0;
    start_scan(16, '{ef: 0, es: 0, er: 0, inc: 3, dec: 3, lc: 0}, 1'b1);
    wait_inc(3);
    pulse_abort();
    wait_done();

    // Zero steps with a simultaneous abort: start wins, no PSEN, fixed latency.
    mode = 2;
    @(negedge clk);
    abort = 1'b1;
    start_scan(0, '{ef: 0, es: 0, er: 0, inc: 0, dec: 0, lc: 256}, 1'b1);
    wait_done();
    // start cycle + settle + samples + RECORD + RETURN
    check("num0_latency", done_cyc - start_cyc, Settle + Samples + 3);

    // Reset in the middle of a phase step.
    mode = 2;
    start_scan(4, '{ef: 0, es: 0, er: 0, inc: 0, dec: 0, lc: 0}, 1'b0);
    wait_inc(1);
    check("last_count_pre_rst", last_count, 256);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid_rst");
    rst = 1'b0;
    repeat (50) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
